// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 host-side blocks (transmitter and
// the ps2_keyboard receiver that sits beside it).
//   ps2_tx_state_t : transmitter FSM states
//   CMD_* / RSP_*  : common keyboard command and response bytes
//   ps2_odd_parity : parity bit that makes the 9-bit {parity, data} odd
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SEND      = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // Data bits + parity bit + stop bit; the start bit is driven separately.
  localparam int FRAME_W = 10;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Command/status bundle between a controller (master) and ps2_host_tx (slave).
//   tx_data, tx_valid : command byte and send request       (master -> slave)
//   tx_ready          : transmitter idle, can accept a byte  (slave -> master)
//   busy              : ~tx_ready, doubles as the receiver ignore input
//   done              : one-cycle pulse ending every accepted transfer
//   ack_err           : with done, device answered NACK (data high at ACK)
//   timeout_err       : with done, device stopped clocking
//   dbg_state         : current transmitter FSM state
//
// Handshake: a byte is transferred on every rising clk edge where tx_valid and
// tx_ready are both high; tx_data is sampled on that same edge. tx_valid seen
// while tx_ready is low is simply not taken, and a request held high across a
// transfer is accepted on the first ready cycle after done.
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;
  logic          ack_err;
  logic          timeout_err;
  ps2_tx_state_t dbg_state;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err, dbg_state
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err, dbg_state
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Two-flop synchronizer for the raw PS/2 clock and data lines, plus a
// falling-edge strobe for each synchronized line. Shared with the receiver.
//   clk, reset        : system clock, synchronous active-high reset
//   i_ps2_clk/data    : raw asynchronous line levels
//   o_clk/data_sync   : synchronized levels
//   o_clk/data_fall   : one-cycle strobe, synced value went 1 -> 0
// All flops reset to 1 (idle bus level) so no false edge follows reset.
// ----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall,
  output logic o_data_fall
);

  // [0] metastability flop, [1] synchronized value, [2] previous synced value
  logic [2:0] r_clk_sh;
  logic [2:0] r_data_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sh  <= 3'b111;
      r_data_sh <= 3'b111;
    end else begin
      r_clk_sh  <= {r_clk_sh[1:0], i_ps2_clk};
      r_data_sh <= {r_data_sh[1:0], i_ps2_data};
    end
  end

  assign o_clk_sync  = r_clk_sh[1];
  assign o_data_sync = r_data_sh[1];
  assign o_clk_fall  = r_clk_sh[2] & ~r_clk_sh[1];
  assign o_data_fall = r_data_sh[2] & ~r_data_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard.
//   clk, reset                : 100 MHz clock, synchronous active-high reset
//   tx (slave)                : command handshake and status pulses
//   ps2_clk_in, ps2_data_in   : raw open-drain line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe   : 1 = pull the line low, 0 = release
// Sequence: hold clock low for INHIBIT_CYCLES, pull data low (start bit),
// release clock, then present one bit after every device clock fall (data
// LSB first, odd parity, stop), read the ACK on the 11th fall and wait for
// the bus to go idle. A watchdog aborts the transfer if the device has not
// finished within TIMEOUT_CYCLES of the clock release.
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_t        r_state,     w_state_n;
  logic [FRAME_W-1:0]   r_frame,     w_frame_n;
  logic [INH_W-1:0]     r_inh_cnt,   w_inh_cnt_n;
  logic [TO_W-1:0]      r_to_cnt,    w_to_cnt_n;
  logic [3:0]           r_bit_cnt,   w_bit_cnt_n;
  logic                 r_clk_oe,    w_clk_oe_n;
  logic                 r_data_oe,   w_data_oe_n;
  logic                 r_ack_flag,  w_ack_flag_n;
  logic                 r_done,      w_done_n;
  logic                 r_ack_err,   w_ack_err_n;
  logic                 r_to_err,    w_to_err_n;

  logic w_clk_s, w_data_s, w_clk_fall, w_unused_data_fall;
  logic w_in_window, w_to_hit, w_inh_start, w_inh_last;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_clk_sync  (w_clk_s),
    .o_data_sync (w_data_s),
    .o_clk_fall  (w_clk_fall),
    .o_data_fall (w_unused_data_fall)
  );

  // The watchdog only runs once the device owns the clock.
  assign w_in_window = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // Counter value k means the clock has been held low for k+1 cycles.
  assign w_inh_start = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign w_inh_last  = (r_inh_cnt == INH_W'(INHIBIT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_ack_flag <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_frame    <= w_frame_n;
      r_inh_cnt  <= w_inh_cnt_n;
      r_to_cnt   <= w_to_cnt_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_clk_oe   <= w_clk_oe_n;
      r_data_oe  <= w_data_oe_n;
      r_ack_flag <= w_ack_flag_n;
      r_done     <= w_done_n;
      r_ack_err  <= w_ack_err_n;
      r_to_err   <= w_to_err_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_frame_n    = r_frame;
    w_inh_cnt_n  = r_inh_cnt;
    w_to_cnt_n   = r_to_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    w_clk_oe_n   = r_clk_oe;
    w_data_oe_n  = r_data_oe;
    w_ack_flag_n = r_ack_flag;
    w_done_n     = 1'b0;
    w_ack_err_n  = 1'b0;
    w_to_err_n   = 1'b0;

    if (w_in_window) begin
      w_to_cnt_n = r_to_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (tx.tx_valid) begin
          w_state_n    = INHIBIT;
          w_frame_n    = {1'b1, ps2_odd_parity(tx.tx_data), tx.tx_data};
          w_clk_oe_n   = 1'b1;
          w_data_oe_n  = 1'b0;
          w_inh_cnt_n  = '0;
          w_bit_cnt_n  = '0;
          w_ack_flag_n = 1'b0;
        end
      end

      INHIBIT: begin
        if (w_inh_last) begin
          w_clk_oe_n = 1'b0;
          w_to_cnt_n = '0;
          w_state_n  = SEND;
        end else begin
          w_inh_cnt_n = r_inh_cnt + 1'b1;
          if (w_inh_start) begin
            w_data_oe_n = 1'b1;           // start bit, clock still held low
          end
        end
      end

      SEND: begin
        if (w_clk_fall) begin
          // Line is open-drain: pulling low sends a 0.
          w_data_oe_n = ~r_frame[0];
          w_frame_n   = {1'b0, r_frame[FRAME_W-1:1]};
          w_bit_cnt_n = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 4'd9) begin    // 10th fall: stop bit now on the line
            w_state_n = ACK;
          end
        end
      end

      ACK: begin
        if (w_clk_fall) begin
          w_ack_flag_n = w_data_s;        // device holds data low to acknowledge
          w_state_n    = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (w_clk_s && w_data_s) begin
          w_done_n    = 1'b1;
          w_ack_err_n = r_ack_flag;
          w_state_n   = IDLE;
        end
      end

      default: w_state_n = IDLE;
    endcase

    // Watchdog overrides whatever the bit-level logic wanted this cycle.
    if (w_in_window && w_to_hit) begin
      w_clk_oe_n  = 1'b0;
      w_data_oe_n = 1'b0;
      w_done_n    = 1'b1;
      w_ack_err_n = 1'b0;
      w_to_err_n  = 1'b1;
      w_state_n   = IDLE;
    end
  end

  assign ps2_clk_oe     = r_clk_oe;
  assign ps2_data_oe    = r_data_oe;
  assign tx.tx_ready    = (r_state == IDLE);
  assign tx.busy        = (r_state != IDLE);
  assign tx.done        = r_done;
  assign tx.ack_err     = r_ack_err;
  assign tx.timeout_err = r_to_err;
  assign tx.dbg_state   = r_state;

endmodule
